// File: rtl/cmos_cam_gen.sv
// cmos_cam_gen -- synthetic CMOS camera timing generator.
//
// Emits hsync/vsync/href timing for a raster of
// (H_SYNC+H_BP+H_ACTIVE+H_FP) x (V_SYNC+V_BP+V_ACTIVE+V_FP) clocks and,
// for every valid pixel, the byte address of that pixel inside an image
// file held in memory (BMP-style: header offset, optional bottom-up rows).
//
// Ports:
//   clk, rst_n   : clock (rising edge), async active-low reset
//   enable       : level request to generate frames
//   cmos_hsync   : line sync, active level HS_POL
//   cmos_vsync   : frame sync, active level VS_POL
//   cmos_href    : pixel valid
//   cmos_index   : byte address of the current pixel (0 when href=0)
//   frame_done   : one-cycle pulse when the last position of a frame leaves
//                  the pipeline
//   frame_cnt    : frames completed since leaving IDLE (saturating)
//
// Optional feature: define CMOS_CAM_ROW_PAD_EN to pad each image row to a
// multiple of 4 bytes (BMP row alignment). Default build: rows are packed.
//
// Outputs are two register stages behind the counters: stage 1 decodes
// sync/active/coordinates, stage 2 forms the address and drives the pins.
module cmos_cam_gen #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 3,
  parameter int unsigned V_BP       = 21,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned BYTES_PP   = 3,   // 3 or 4 only
  parameter int unsigned HDR_OFFSET = 54,
  parameter bit          BOTTOM_UP  = 1'b1,
  parameter int unsigned FRAMES     = 0    // 0 = unlimited
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        cmos_hsync,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [31:0] cmos_index,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam logic [31:0] H_TOTAL = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [31:0] V_TOTAL = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [31:0] H_LAST  = H_TOTAL - 32'd1;
  localparam logic [31:0] V_LAST  = V_TOTAL - 32'd1;
  localparam logic [31:0] H_START = 32'(H_SYNC + H_BP);
  localparam logic [31:0] H_END   = H_START + 32'(H_ACTIVE);
  localparam logic [31:0] V_START = 32'(V_SYNC + V_BP);
  localparam logic [31:0] V_END   = V_START + 32'(V_ACTIVE);
  localparam logic [31:0] ROW_B   = 32'(H_ACTIVE * BYTES_PP);
`ifdef CMOS_CAM_ROW_PAD_EN
  localparam logic [31:0] STRIDE  = (ROW_B + 32'd3) & ~32'd3;
`else
  localparam logic [31:0] STRIDE  = ROW_B;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] hcnt, vcnt;
  logic        run, frame_end, limit_hit, h_act, v_act;

  // stage-1 registers
  logic        s1_hs, s1_vs, s1_act, s1_fe;
  logic [31:0] s1_x, s1_row;

  assign run       = (state == RUN);
  assign frame_end = (hcnt == H_LAST) && (vcnt == V_LAST);
  // frame_cnt lags the counters by two clocks, but a frame is far longer
  // than that, so it is up to date at every frame end.
  assign limit_hit = (FRAMES != 0) && (({16'd0, frame_cnt} + 32'd1) == FRAMES);
  assign h_act     = (hcnt >= H_START) && (hcnt < H_END);
  assign v_act     = (vcnt >= V_START) && (vcnt < V_END);

  // FSM, raster counters and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hcnt      <= '0;
      vcnt      <= '0;
      frame_cnt <= '0;
    end else begin
      // counts on the same edge that raises frame_done
      if (s1_fe && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      case (state)
        IDLE: if (enable) begin
          state     <= RUN;
          frame_cnt <= '0;  // a fresh run wins over a late frame_done
        end
        RUN: begin
          if (frame_end) begin
            hcnt <= '0;
            vcnt <= '0;
            if (limit_hit)    state <= DONE;
            else if (!enable) state <= IDLE;
          end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= vcnt + 32'd1;
          end else begin
            hcnt <= hcnt + 32'd1;
          end
        end
        DONE: if (!enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: decode position. Outside RUN everything decodes as idle so the
  // pipeline drains to inactive levels without glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hs  <= ~HS_POL;
      s1_vs  <= ~VS_POL;
      s1_act <= 1'b0;
      s1_fe  <= 1'b0;
      s1_x   <= '0;
      s1_row <= '0;
    end else begin
      s1_hs  <= (run && hcnt < 32'(H_SYNC)) ? HS_POL : ~HS_POL;
      s1_vs  <= (run && vcnt < 32'(V_SYNC)) ? VS_POL : ~VS_POL;
      s1_act <= run && h_act && v_act;
      s1_fe  <= run && frame_end;
      s1_x   <= hcnt - H_START;
      s1_row <= BOTTOM_UP ? (32'(V_ACTIVE) - 32'd1) - (vcnt - V_START)
                          : (vcnt - V_START);
    end
  end

  // Stage 2: address formation and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmos_hsync <= ~HS_POL;
      cmos_vsync <= ~VS_POL;
      cmos_href  <= 1'b0;
      cmos_index <= '0;
      frame_done <= 1'b0;
    end else begin
      cmos_hsync <= s1_hs;
      cmos_vsync <= s1_vs;
      cmos_href  <= s1_act;
      cmos_index <= s1_act ? 32'(HDR_OFFSET) + s1_row * STRIDE + s1_x * 32'(BYTES_PP)
                           : '0;
      frame_done <= s1_fe;
    end
  end

endmodule

// File: tb/tb_cmos_cam_gen.sv
// Directed bench for cmos_cam_gen on a 9x6 raster (5x3 active pixels).
// Two instances: u_m (BOTTOM_UP=1, unlimited frames) and u_l (BOTTOM_UP=0,
// FRAMES=2). Per-cycle timing is checked against a raster model; pixel
// addresses go through a per-instance scoreboard queue filled when the
// stimulus starts a frame and drained by a monitor on every href cycle.
module tb_cmos_cam_gen;

  logic        clk = 1'b0, rst_n = 1'b0, en_m = 1'b0, en_l = 1'b0;
  logic        hs_m, vs_m, hr_m, fd_m, hs_l, vs_l, hr_l, fd_l;
  logic [31:0] ix_m, ix_l;
  logic [15:0] fc_m, fc_l;

  logic [31:0] q_m[$], q_l[$];
  int n_chk = 0, n_pass = 0;

`ifdef CMOS_CAM_ROW_PAD_EN
  localparam int STRIDE = 16;
`else
  localparam int STRIDE = 15;
`endif

  always #5 clk = ~clk;

  cmos_cam_gen #(.H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0),
    .BYTES_PP(3), .HDR_OFFSET(54), .BOTTOM_UP(1'b1), .FRAMES(0)) u_m (
    .clk(clk), .rst_n(rst_n), .enable(en_m), .cmos_hsync(hs_m),
    .cmos_vsync(vs_m), .cmos_href(hr_m), .cmos_index(ix_m),
    .frame_done(fd_m), .frame_cnt(fc_m));

  cmos_cam_gen #(.H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0),
    .BYTES_PP(3), .HDR_OFFSET(54), .BOTTOM_UP(1'b0), .FRAMES(2)) u_l (
    .clk(clk), .rst_n(rst_n), .enable(en_l), .cmos_hsync(hs_l),
    .cmos_vsync(vs_l), .cmos_href(hr_l), .cmos_index(ix_l),
    .frame_done(fd_l), .frame_cnt(fc_l));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // expected pixel addresses of one frame, in raster order
  task automatic push_frame(input bit bu, input bit lim);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 5; x++) begin
        logic [31:0] row, v;
        row = bu ? 32'(2 - y) : 32'(y);
        v = 32'd54 + row * 32'(STRIDE) + 32'(x * 3);
        if (lim) q_l.push_back(v); else q_m.push_back(v);
      end
  endtask

  // Raster model: sample i is taken just after the i-th edge following the
  // edge that entered RUN; outputs then show counter position k = i-2.
  // k_end is the last position the generator runs (its final frame end).
  task automatic chk_cyc(input string nm, input int i, input int k_end,
                         input logic hs, input logic vs, input logic hr,
                         input logic [31:0] ix, input logic fd, input logic [15:0] fc);
    int k, h, v, last, e_fc;
    bit run, e_hs, e_vs, e_hr, e_fd;
    k = i - 2;
    run = (k >= 0) && (k <= k_end);
    h = run ? k % 9 : 0;
    v = run ? (k / 9) % 6 : 0;
    e_hs = run ? (h >= 2) : 1'b1;
    e_vs = run ? (v >= 1) : 1'b1;
    e_hr = run && v >= 2 && v < 5 && h >= 3 && h < 8;
    e_fd = run && (k % 54 == 53);
    last = (k < k_end) ? k : k_end;
    e_fc = (k < 0) ? 0 : (last + 1) / 54;
    chk({nm, "_hsync"}, 32'(hs), 32'(e_hs));
    chk({nm, "_vsync"}, 32'(vs), 32'(e_vs));
    chk({nm, "_href"},  32'(hr), 32'(e_hr));
    chk({nm, "_done"},  32'(fd), 32'(e_fd));
    chk({nm, "_fcnt"},  32'(fc), 32'(e_fc));
    if (!hr) chk({nm, "_idx_zero"}, ix, 32'd0);
  endtask

  // scoreboard monitors: every href pixel must match the next queued address
  always @(posedge clk) begin
    #1;
    if (hr_m === 1'b1) chk("sb_idx_m", ix_m, (q_m.size() != 0) ? q_m.pop_front() : 32'hFFFF_FFFF);
    if (hr_l === 1'b1) chk("sb_idx_l", ix_l, (q_l.size() != 0) ? q_l.pop_front() : 32'hFFFF_FFFF);
  end

  initial begin
    int first, nfd, fd1, fd2;
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_hsync", 32'(hs_m), 32'd1);
    chk("rst_vsync", 32'(vs_m), 32'd1);
    chk("rst_href",  32'(hr_m), 32'd0);
    chk("rst_index", ix_m, 32'd0);
    chk("rst_done",  32'(fd_m), 32'd0);
    chk("rst_fcnt",  32'(fc_m), 32'd0);
    rst_n = 1'b1;

    // three frames; enable dropped at vcnt=3 of the third, which must finish
    @(negedge clk);
    en_m = 1'b1;
    push_frame(1'b1, 1'b0); push_frame(1'b1, 1'b0); push_frame(1'b1, 1'b0);
    first = -1;
    for (int i = 0; i <= 175; i++) begin
      @(posedge clk); #1;
      chk_cyc("m", i, 161, hs_m, vs_m, hr_m, ix_m, fd_m, fc_m);
      if (first < 0 && hr_m === 1'b1) first = i;
      if (i == 136) en_m = 1'b0;
    end
    chk("first_href_lat", 32'(first), 32'd23);
    chk("m_fcnt_after_stop", 32'(fc_m), 32'd3);
    chk("m_sb_drained", 32'(q_m.size()), 32'd0);

    // restart clears frame_cnt; then reset pulsed low mid-line during href
    en_m = 1'b1;
    push_frame(1'b1, 1'b0);
    for (int i = 0; i <= 33; i++) begin
      @(posedge clk); #1;
      chk_cyc("m2", i, 100000, hs_m, vs_m, hr_m, ix_m, fd_m, fc_m);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_hsync", 32'(hs_m), 32'd1);
    chk("mid_rst_vsync", 32'(vs_m), 32'd1);
    chk("mid_rst_href",  32'(hr_m), 32'd0);
    chk("mid_rst_index", ix_m, 32'd0);
    chk("mid_rst_done",  32'(fd_m), 32'd0);
    q_m.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(1'b1, 1'b0);
    for (int i = 0; i <= 60; i++) begin
      @(posedge clk); #1;
      chk_cyc("m3", i, 53, hs_m, vs_m, hr_m, ix_m, fd_m, fc_m);
      if (i == 40) en_m = 1'b0;
    end
    chk("m3_sb_drained", 32'(q_m.size()), 32'd0);

    // frame limit of two, top-down order, enable held high
    en_l = 1'b1;
    push_frame(1'b0, 1'b1); push_frame(1'b0, 1'b1);
    nfd = 0; fd1 = 0; fd2 = 0;
    for (int i = 0; i <= 170; i++) begin
      @(posedge clk); #1;
      chk_cyc("l", i, 107, hs_l, vs_l, hr_l, ix_l, fd_l, fc_l);
      if (fd_l === 1'b1) begin
        nfd++;
        if (nfd == 1) fd1 = i; else fd2 = i;
      end
    end
    chk("l_done_count", 32'(nfd), 32'd2);
    chk("l_done_spacing", 32'(fd2 - fd1), 32'd54);
    chk("l_fcnt_final", 32'(fc_l), 32'd2);
    chk("l_sb_drained", 32'(q_l.size()), 32'd0);
    en_l = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
